// File: rtl/render_fb_writer.sv
// Renderer pixel-stream sink: window check, RGB888->RGB444, linear framebuffer address.
// Optional macro RENDER_FB_ROUND_EN selects rounded colour conversion instead of truncation.
module render_fb_writer #(
  parameter int unsigned START_X       = 390,
  parameter int unsigned START_Y       = 390,
  parameter int unsigned END_X         = 634,
  parameter int unsigned END_Y         = 765,
  parameter int unsigned REGION_DIVIDE = 530,
  parameter int unsigned COL_SHIFT     = 2,
  parameter int unsigned ADDR_W        = 17
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [23:0]       s_axis_pixel_tdata,
  input  logic [10:0]       s_axis_pixel_hcount,
  input  logic [9:0]        s_axis_pixel_vcount,
  input  logic              s_axis_pixel_tvalid,
  output logic              s_axis_pixel_tready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_din,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              err_oob
);

  localparam int unsigned Width = END_X - START_X;

  typedef struct packed {
    logic [23:0] data;
    logic [10:0] h;
    logic [9:0]  v;
  } beat_t;

  function automatic logic [3:0] conv_chan(input logic [7:0] c);
`ifdef RENDER_FB_ROUND_EN
    logic [8:0] s;
    s = {1'b0, c} + 9'd8;
    if (s > 9'd255) s = 9'd255;
    return 4'(s >> 4);
`else
    return 4'(c >> 4);
`endif
  endfunction

  // Skid buffer
  beat_t       buf_q [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        tready_q;
  logic        push, pop, adv, wr_idx;
  beat_t       in_beat, head;

  // Stage A / stage B / output register state
  logic              a_valid_q, a_last_q;
  logic [10:0]       a_dx_q;
  logic [9:0]        a_dy_q;
  logic [11:0]       a_rgb_q;
  logic              b_valid_q, b_last_q;
  logic [10:0]       b_dx_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [11:0]       b_rgb_q;
  logic              we_q, out_last_q, done_q, oob_q;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       din_q;
  logic [7:0]        fcnt_q;

  // Stage A combinational results
  int          h_i, v_i, dx_i, dy_i;
  logic        in_win, is_last;
  logic [11:0] rgb_d;

  assign s_axis_pixel_tready = tready_q;
  assign fb_we       = we_q;
  assign fb_addr     = addr_q;
  assign fb_din      = din_q;
  assign frame_done  = done_q;
  assign frame_count = fcnt_q;
  assign err_oob     = oob_q;

  assign in_beat = '{data: s_axis_pixel_tdata, h: s_axis_pixel_hcount, v: s_axis_pixel_vcount};
  assign head    = buf_q[0];
  // Whole pipeline advances unless the output register holds an unaccepted write.
  assign adv     = !(we_q && !fb_ready);
  assign push    = s_axis_pixel_tvalid && tready_q;
  assign pop     = (cnt_q != 2'd0) && adv;
  // A push only happens with cnt_q <= 1; a same-cycle pop shifts slot 1 down first.
  assign wr_idx  = !pop && cnt_q[0];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q    <= 2'd0;
      tready_q <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tready_q <= (cnt_d < 2'd2);
      if (pop) buf_q[0] <= buf_q[1];
      if (push) buf_q[wr_idx] <= in_beat;
    end
  end

  always_comb begin
    h_i     = int'(head.h);
    v_i     = int'(head.v);
    in_win  = (h_i >= int'(START_X)) && (h_i < int'(END_X)) &&
              (v_i >= int'(START_Y)) && (v_i < int'(END_Y));
    is_last = (h_i == int'(END_X) - 1) && (v_i == int'(END_Y) - 1);
    dx_i    = h_i - int'(START_X) - ((v_i < int'(REGION_DIVIDE)) ? int'(COL_SHIFT) : 0);
    if (dx_i < 0) dx_i = 0;
    dy_i    = v_i - int'(START_Y);
    rgb_d   = {conv_chan(head.data[23:16]), conv_chan(head.data[15:8]),
               conv_chan(head.data[7:0])};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_dx_q    <= '0;
      a_dy_q    <= '0;
      a_rgb_q   <= '0;
      oob_q     <= 1'b0;
    end else if (adv) begin
      a_valid_q <= pop && in_win;
      a_last_q  <= is_last;
      a_dx_q    <= 11'(dx_i);
      a_dy_q    <= 10'(dy_i);
      a_rgb_q   <= rgb_d;
      if (pop && !in_win) oob_q <= 1'b1;
    end
  end

  // Stage B registers the row base so the adder into the output register stays short.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b_valid_q <= 1'b0;
      b_last_q  <= 1'b0;
      b_dx_q    <= '0;
      b_base_q  <= '0;
      b_rgb_q   <= '0;
    end else if (adv) begin
      b_valid_q <= a_valid_q;
      b_last_q  <= a_last_q;
      b_dx_q    <= a_dx_q;
      b_base_q  <= ADDR_W'(32'(a_dy_q) * Width);
      b_rgb_q   <= a_rgb_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      we_q       <= 1'b0;
      out_last_q <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else if (adv) begin
      we_q <= b_valid_q;
      if (b_valid_q) begin
        out_last_q <= b_last_q;
        addr_q     <= b_base_q + ADDR_W'(b_dx_q);
        din_q      <= b_rgb_q;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done_q <= 1'b0;
      fcnt_q <= 8'd0;
    end else begin
      done_q <= we_q && fb_ready && out_last_q;
      if (we_q && fb_ready && out_last_q) fcnt_q <= fcnt_q + 8'd1;
    end
  end

endmodule
